// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction memory (one-cycle read latency)
// and hands {instr, instr_pc} to decode over a valid/ready handshake.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_1000,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_1000,
    parameter int unsigned IMEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_data_out,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Window end kept 33 bits wide so a window touching the top of memory cannot wrap.
    localparam logic [32:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + 33'(IMEM_BYTES);

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic        rsp_valid;
    logic        fault_next;
    logic [31:0] fault_pc_next;
    logic        pc_bad;
    logic        handshake;

    assign pc_bad = (fetch_pc[1:0] != 2'b00)
                  | (fetch_pc < IMEM_BASE)
                  | ({1'b0, fetch_pc} >= IMEM_LIMIT);

    assign instr       = imem_data_out;
    assign instr_pc    = fetch_pc;
    assign instr_valid = (state == RUN) & rsp_valid & ~redirect_valid & ~pc_bad;
    assign handshake   = instr_valid & instr_ready;
    assign halted      = (state == HALT);

    always_comb begin
        state_next    = state;
        imem_address  = fetch_pc;
        fault_next    = fault;
        fault_pc_next = fault_pc;
        case (state)
            IDLE: begin
                imem_address = RESET_PC;
                state_next   = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    imem_address = redirect_target;
                end else if (handshake) begin
                    imem_address = fetch_pc + 32'd4;
                end
                // Redirect outranks everything; a bad PC faults before a halt is honoured.
                if (redirect_valid) begin
                    state_next = RUN;
                end else if (pc_bad && rsp_valid) begin
                    fault_next    = 1'b1;
                    fault_pc_next = fetch_pc;
                    state_next    = HALT;
                end else if (halt_req) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    imem_address = redirect_target;
                    state_next   = RUN;
                    fault_next   = 1'b0;
                end
            end
            default: begin
                imem_address = RESET_PC;
                state_next   = IDLE;
            end
        endcase
    end

    // fetch_pc follows the presented address so the returned data always matches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            rsp_valid   <= 1'b0;
            fault       <= 1'b0;
            fault_pc    <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            state     <= state_next;
            fetch_pc  <= imem_address;
            rsp_valid <= (state_next != IDLE);
            fault     <= fault_next;
            fault_pc  <= fault_pc_next;
            if (handshake) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule
